// File: rtl/div_seq_ctrl_if.sv
// =============================================================================
// Module      : div_seq_ctrl_if
// Description : Request/result bundle between the execute stage and the
//               divide sequencing controller.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

interface div_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            signed_i;
    logic            rem_sel_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            kill_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    modport master (
        output start_i, signed_i, rem_sel_i, dividend_i, divisor_i, kill_i,
        input  stall_o, done_o, result_o, busy_o
    );

    modport slave (
        input  start_i, signed_i, rem_sel_i, dividend_i, divisor_i, kill_i,
        output stall_o, done_o, result_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/div_seq_ctrl.sv
// =============================================================================
// Module      : div_seq_ctrl
// Description : RV32M DIV/DIVU/REM/REMU sequencer, 32-step restoring divider.
//               Optional macro DIV_EARLY_OUT_EN: finish at once when
//               |dividend| < |divisor|.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module div_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    div_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN-1:0] result_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            rem_sel_q;
    logic            done_q;

    logic            accept_d;
    logic [XLEN-1:0] dvd_mag_d;
    logic [XLEN-1:0] dvs_mag_d;
    logic            div_zero_d;
    logic            ovf_d;
    logic            early_d;
    logic [XLEN:0]   shift_d;
    logic [XLEN:0]   trial_d;
    logic [XLEN-1:0] quo_fix_d;
    logic [XLEN-1:0] rem_fix_d;

    always_comb begin
        accept_d   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                     bus.start_i && !bus.kill_i;
        dvd_mag_d  = (bus.signed_i && bus.dividend_i[XLEN-1]) ? -bus.dividend_i
                                                              : bus.dividend_i;
        dvs_mag_d  = (bus.signed_i && bus.divisor_i[XLEN-1]) ? -bus.divisor_i
                                                             : bus.divisor_i;
        div_zero_d = (bus.divisor_i == '0);
        ovf_d      = bus.signed_i &&
                     (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.divisor_i == '1);
`ifdef DIV_EARLY_OUT_EN
        early_d    = (dvd_mag_d < dvs_mag_d);
`else
        early_d    = 1'b0;
`endif
        // Bit XLEN of the trial difference is the borrow: set means restore.
        shift_d    = {rem_q, quo_q[XLEN-1]};
        trial_d    = shift_d - {1'b0, dvsr_q};
        quo_fix_d  = neg_quo_q ? -quo_q : quo_q;
        rem_fix_d  = neg_rem_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.kill_i) begin
                state_q <= ST_IDLE;
            end else if (accept_d) begin
                rem_sel_q <= bus.rem_sel_i;
                neg_quo_q <= bus.signed_i &
                             (bus.dividend_i[XLEN-1] ^ bus.divisor_i[XLEN-1]);
                neg_rem_q <= bus.signed_i & bus.dividend_i[XLEN-1];
                dvsr_q    <= dvs_mag_d;
                quo_q     <= dvd_mag_d;
                rem_q     <= '0;
                if (div_zero_d) begin
                    result_q <= bus.rem_sel_i ? bus.dividend_i : '1;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end else if (ovf_d) begin
                    result_q <= bus.rem_sel_i ? '0 : bus.dividend_i;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end else if (early_d) begin
                    result_q <= bus.rem_sel_i ? bus.dividend_i : '0;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end else begin
                    cnt_q   <= CW'(XLEN - 1);
                    state_q <= ST_CALC;
                end
            end else begin
                case (state_q)
                    ST_CALC: begin
                        if (!trial_d[XLEN]) begin
                            rem_q <= trial_d[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_q <= shift_d[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b0};
                        end
                        if (cnt_q == '0) begin
                            state_q <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    ST_FIX: begin
                        result_q <= rem_sel_q ? rem_fix_d : quo_fix_d;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Stall covers the accept cycle so the pipeline holds the operands.
    assign bus.stall_o  = accept_d || (state_q == ST_CALC) || (state_q == ST_FIX);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.busy_o   = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
// =============================================================================
// Module      : tb_div_seq_ctrl
// Description : Directed self-checking bench for div_seq_ctrl.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_div_seq_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   passed;

    div_seq_ctrl_if #(.XLEN(32)) bus ();

    div_seq_ctrl #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 34;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Presents a request (optionally waiting for the next cycle first) and
    // follows it to done_o, checking latency, stall length and result.
    task automatic do_op(input bit wait_first, input bit sg, input bit rs,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat,
                         input string tag);
        int lat;
        int stl;
        if (wait_first) @(negedge clk);
        bus.start_i    = 1'b1;
        bus.signed_i   = sg;
        bus.rem_sel_i  = rs;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        #1;
        stl = bus.stall_o ? 1 : 0;
        lat = 0;
        do begin
            @(negedge clk);
            bus.start_i = 1'b0;
            #1;
            lat++;
            if (!bus.done_o && bus.stall_o) stl++;
        end while (!bus.done_o && lat < 100);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " stall cycles"}, 32'(stl), (exp_lat == 1) ? 32'd1 : 32'd34);
        check({tag, " stall at done"}, {31'd0, bus.stall_o}, 32'd0);
        check({tag, " result"}, bus.result_o, exp_res);
    endtask

    initial begin
        bit saw_done;
        logic [31:0] prev;
        checks = 0;
        passed = 0;
        rst            = 1'b0;
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.rem_sel_i  = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.kill_i     = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset stall", {31'd0, bus.stall_o}, 32'd0);
        check("reset done", {31'd0, bus.done_o}, 32'd0);
        check("reset busy", {31'd0, bus.busy_o}, 32'd0);
        check("reset result", bus.result_o, 32'h0000_0000);

        // Kill overrides a simultaneous start.
        bus.start_i = 1'b1; bus.kill_i = 1'b1;
        bus.dividend_i = 32'd10; bus.divisor_i = 32'd3;
        #1;
        check("kill+start stall", {31'd0, bus.stall_o}, 32'd0);
        @(negedge clk);
        bus.start_i = 1'b0; bus.kill_i = 1'b0;
        #1;
        check("kill+start busy", {31'd0, bus.busy_o}, 32'd0);

        do_op(1, 1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "DIV -7/2");
        do_op(1, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "REM -7/2");
        do_op(1, 1, 1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 34, "REM 7/-2");
        do_op(1, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, "DIVU max/1");
        do_op(1, 0, 0, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, "DIVU 100/0");
        do_op(1, 0, 1, 32'd100, 32'd0, 32'h0000_0064, 1, "REMU 100/0");
        do_op(1, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf");
        do_op(1, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "REM ovf");

        // Kill in the middle of a divide.
        prev = bus.result_o;
        saw_done = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.rem_sel_i = 1'b0;
        bus.dividend_i = 32'd1000; bus.divisor_i = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (bus.done_o) saw_done = 1'b1;
        end
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        #1;
        if (bus.done_o) saw_done = 1'b1;
        check("kill busy", {31'd0, bus.busy_o}, 32'd0);
        check("kill no done", {31'd0, saw_done}, 32'd0);
        check("kill result held", bus.result_o, prev);
        do_op(1, 0, 0, 32'd1000, 32'd3, 32'd333, 34, "DIVU after kill");

        // Back-to-back: second request presented in the first DONE cycle.
        do_op(1, 0, 0, 32'd1000, 32'd3, 32'd333, 34, "b2b first");
        do_op(0, 0, 1, 32'd1000, 32'd3, 32'd1, 34, "b2b second");

        do_op(1, 0, 0, 32'd5, 32'd9, 32'd0, EARLY_LAT, "DIVU 5/9");
        do_op(1, 1, 1, 32'hFFFF_FFFB, 32'd9, 32'hFFFF_FFFB, EARLY_LAT, "REM -5/9");

        // Reset mid-operation abandons it.
        @(negedge clk);
        bus.start_i = 1'b1; bus.dividend_i = 32'd77; bus.divisor_i = 32'd7;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid-op reset busy", {31'd0, bus.busy_o}, 32'd0);
        check("mid-op reset result", bus.result_o, 32'd0);
        check("mid-op reset done", {31'd0, bus.done_o}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

`default_nettype wire
